uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 82 ++++++++
 rtl/uart_tx_buffered.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_e     : transmitter FSM state encodings
//   cycles_per_bit : clock cycles per line bit (integer division)
//   cnt_width      : counter width able to hold 0..n-1 (minimum 1 bit)
// Optional feature macro: UART_TX_PARITY_EN adds the StParity state.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StStop   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        StParity = 3'd4
`endif
    } tx_state_e;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter.
// Ports:
//   clk_i    : system clock, rising edge
//   srst_ni  : synchronous active-low reset, empties the buffer
//   push_i   : write data_i (ignored while full)
//   pop_i    : drop the head entry (ignored while empty)
//   data_i   : entry to write
//   full_o   : occupancy equals Depth (registered occupancy)
//   empty_o  : occupancy is zero
//   head_o   : oldest entry
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             srst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned AddrW = cnt_width(Depth);
    localparam int unsigned CountW = AddrW + 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CountW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Full/empty come from registered occupancy, so a push into a full
    // buffer is dropped even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CountW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small FIFO feeding a start/data/stop serialiser.
// Ports:
//   clk         : system clock, rising edge
//   resetn      : synchronous active-low reset; abandons any frame in flight
//   tx_data     : byte to transmit
//   tx_valid    : tx_data offered this cycle
//   tx_ready    : buffer can accept a byte
//   tx_busy     : frame in progress or buffer non-empty
//   tx_overflow : one-cycle pulse after a byte was offered while not ready
//   uart_txd    : registered serial line, idle high
// Optional feature macro: UART_TX_PARITY_EN inserts an even parity bit after
// the data bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [PAYLOAD_BITS-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    tx_busy,
    output logic                    tx_overflow,
    output logic                    uart_txd
);

    localparam int unsigned CyclesPerBit = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned CntW = cnt_width(CyclesPerBit);
    localparam int unsigned IdxW = cnt_width(PAYLOAD_BITS);
    localparam logic [CntW-1:0] CntLast = CntW'(CyclesPerBit - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(PAYLOAD_BITS - 1);

    tx_state_e               state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    txd_q, txd_d;
    logic                    ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic                    fifo_full, fifo_empty, fifo_pop;
    logic [PAYLOAD_BITS-1:0] fifo_head;
    logic                    bit_end, load;

    uart_tx_fifo #(
        .Width(PAYLOAD_BITS),
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .srst_ni(resetn),
        .push_i (tx_valid),
        .pop_i  (fifo_pop),
        .data_i (tx_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (fifo_head)
    );

    assign tx_ready    = !fifo_full;
    assign tx_busy     = (state_q != StIdle) || !fifo_empty;
    assign tx_overflow = ovf_q;
    assign uart_txd    = txd_q;

    assign ovf_d   = tx_valid && fifo_full;
    assign bit_end = (cnt_q == CntLast);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        load     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                cnt_d = '0;
                load  = !fifo_empty;
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                    txd_d   = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        txd_d   = parity_q;
`else
                        state_d = StStop;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        shift_d = shift_q >> 1;
                        txd_d   = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StStop;
                    txd_d   = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    txd_d   = 1'b1;
                    // Chain straight into the next start bit when data waits.
                    load    = !fifo_empty;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                txd_d   = 1'b1;
            end
        endcase

        // Pop and start bit share one edge, giving one-cycle push-to-line latency.
        if (load) begin
            state_d  = StStart;
            cnt_d    = '0;
            idx_d    = '0;
            shift_d  = fifo_head;
            txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_head;
`endif
        end
    end

    assign fifo_pop = load;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
